// File: rtl/morse_pkg.sv
// Shared Morse symbol codes and classifier state encoding.
// The downstream decoder imports the same codes.
package morse_pkg;

  localparam logic [2:0] SYM_NONE   = 3'b000;
  localparam logic [2:0] SYM_DOT    = 3'b001;
  localparam logic [2:0] SYM_DASH   = 3'b010;
  localparam logic [2:0] SYM_CSPACE = 3'b011;
  localparam logic [2:0] SYM_WSPACE = 3'b100;
  localparam logic [2:0] SYM_ERR    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_WORD
  } state_e;

endpackage

// File: rtl/morse_input_sync.sv
// Two-flop synchroniser for the raw key line with polarity normalisation.
// The flops reset to the released level, so no spurious press is seen after reset.
module morse_input_sync #(
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic serial_inp,
  output logic pressed
);

  localparam logic RELEASED = ~ACTIVE_HIGH;

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = serial_inp;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RELEASED;
      sync_q <= RELEASED;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign pressed = sync_q ^ ~ACTIVE_HIGH;

endmodule

// File: rtl/morse_symbol_classifier.sv
// Morse keying front end: measures press/release run lengths on sample ticks
// and strobes dot, dash, char space, word space or overlong-press error codes.
module morse_symbol_classifier
  import morse_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MIN_PRESS = 2,
  parameter int unsigned DOT_MAX   = 3,
  parameter int unsigned DASH_MAX  = 9,
  parameter int unsigned CHAR_GAP  = 3,
  parameter int unsigned WORD_GAP  = 7,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic       serial_inp,
  output logic [2:0] sym,
  output logic       sym_valid,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PRESS);
  localparam logic [CNT_W-1:0] DOT_C     = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] DASH_C    = CNT_W'(DASH_MAX);
  localparam logic [CNT_W-1:0] CGAP_C    = CNT_W'(CHAR_GAP);
  localparam logic [CNT_W-1:0] WGAP_C    = CNT_W'(WORD_GAP);

  logic pressed;

  morse_input_sync #(
    .ACTIVE_HIGH (ACTIVE_HIGH)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_inp (serial_inp),
    .pressed    (pressed)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             char_open_q, char_open_d;
  logic [2:0]       sym_q, sym_d;
  logic             sym_valid_q, sym_valid_d;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    char_open_d = char_open_q;
    sym_d       = sym_q;
    sym_valid_d = 1'b0;
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    if (sample_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (pressed) begin
            state_d = ST_PRESS;
            cnt_d   = CNT_ONE;
          end
        end
        ST_PRESS: begin
          if (pressed) begin
            cnt_d = cnt_inc;
          end else if (cnt_q < MIN_C) begin
            // Glitch: resume an open character's gap, otherwise nothing was started.
            if (char_open_q) begin
              state_d = ST_GAP;
              cnt_d   = CNT_ONE;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            sym_valid_d = 1'b1;
            if (cnt_q <= DOT_C)       sym_d = SYM_DOT;
            else if (cnt_q <= DASH_C) sym_d = SYM_DASH;
            else                      sym_d = SYM_ERR;
            char_open_d = 1'b1;
            state_d     = ST_GAP;
            cnt_d       = CNT_ONE;
          end
        end
        ST_GAP: begin
          if (pressed) begin
            state_d = ST_PRESS;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CGAP_C) begin
              sym_d       = SYM_CSPACE;
              sym_valid_d = 1'b1;
              char_open_d = 1'b0;
              state_d     = ST_WORD;
            end
          end
        end
        ST_WORD: begin
          if (pressed) begin
            state_d = ST_PRESS;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == WGAP_C) begin
              sym_d       = SYM_WSPACE;
              sym_valid_d = 1'b1;
              state_d     = ST_IDLE;
              cnt_d       = '0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      char_open_q <= 1'b0;
      sym_q       <= SYM_NONE;
      sym_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      char_open_q <= char_open_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
    end
  end

  assign sym       = sym_q;
  assign sym_valid = sym_valid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
